eq_pipe_ctrl: RTL and testbench

//   Sequencer for the EQ sample datapath (clk domain). Pops samples from the data FIFO read side,

---
 rtl/eq_pkg.sv | 26 ++
 rtl/gain_ramp.sv | 40 ++++
 rtl/eq_pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_eq_pipe_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and default latencies for the EQ sample sequencer.
package eq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int DEF_DATA_W       = 24;
  localparam int DEF_RATE_W       = 8;
  localparam int DEF_ISSUE_GAP    = 32;
  localparam int DEF_CONV_LAT     = 6;
  localparam int DEF_FILT_LAT     = 6;
  localparam int DEF_BACK_LAT     = 5;
  localparam int DEF_UNDERRUN_LIM = 4;

  function automatic int pipe_lat(input int conv_lat, input int filt_lat, input int back_lat);
    return conv_lat + filt_lat + back_lat;
  endfunction

  localparam int DEF_PIPE_LAT = pipe_lat(DEF_CONV_LAT, DEF_FILT_LAT, DEF_BACK_LAT);

endpackage

// File: rtl/gain_ramp.sv
// Amplifier gain slewer: one LSB toward the target per step pulse, never overshooting.
module gain_ramp #(
  parameter int RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [RATE_W-1:0] tgt_i,
  input  logic              step_i,
  output logic [RATE_W-1:0] rate_o
);

  localparam logic [RATE_W-1:0] ONE = RATE_W'(1);

  logic [RATE_W-1:0] rate_r;

  function automatic logic [RATE_W-1:0] step_toward(input logic [RATE_W-1:0] cur,
                                                     input logic [RATE_W-1:0] tgt);
    logic [RATE_W-1:0] nxt;
    if (cur < tgt) begin
      nxt = cur + ONE;
    end else if (cur > tgt) begin
      nxt = cur - ONE;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Applied gain register, updated only on amplifier-enable cycles
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rate_r <= '0;
    end else if (step_i) begin
      rate_r <= step_toward(rate_r, tgt_i);
    end
  end

  assign rate_o = rate_r;

endmodule

// File: rtl/eq_pipe_ctrl.sv
// EQ sample sequencer: paced FIFO reads, per-stage enables, gain ramps and FIFO health flags.
module eq_pipe_ctrl
  import eq_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RATE_W       = DEF_RATE_W,
  parameter int ISSUE_GAP    = DEF_ISSUE_GAP,
  parameter int CONV_LAT     = DEF_CONV_LAT,
  parameter int FILT_LAT     = DEF_FILT_LAT,
  parameter int BACK_LAT     = DEF_BACK_LAT,
  parameter int UNDERRUN_LIM = DEF_UNDERRUN_LIM
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              empty_i,
  input  logic              full_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rdreq_o,
  output logic [DATA_W-1:0] data_o,
  output logic              issue_o,
  output logic              filt_ena_o,
  output logic              amp_ena_o,
  input  logic [RATE_W-1:0] lp_tgt_i,
  input  logic [RATE_W-1:0] hp_tgt_i,
  output logic [RATE_W-1:0] lp_rate_o,
  output logic [RATE_W-1:0] hp_rate_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              overrun_o
);

  localparam int         PIPE_LAT = pipe_lat(CONV_LAT, FILT_LAT, BACK_LAT);
  localparam logic [7:0] GAP_LAST = 8'(ISSUE_GAP - 1);
  localparam logic [3:0] MISS_ARM = 4'(UNDERRUN_LIM - 1);

  state_t              state_r;
  logic                rdreq_r;
  logic                issue_r;
  logic [DATA_W-1:0]   data_r;
  logic [7:0]          gap_cnt_r;
  logic [3:0]          miss_cnt_r;
  logic [PIPE_LAT-1:0] dly_r;
  logic                underrun_r;
  logic                overrun_r;

  logic slot_end_s;
  logic line_busy_s;
  logic read_go_s;
  logic miss_step_s;
  logic underrun_set_s;
  logic busy_s;

  // Slot decisions: a slot either launches a read or counts as a miss
  always_comb begin
    slot_end_s     = (gap_cnt_r == GAP_LAST);
    line_busy_s    = issue_r | (|dly_r);
    read_go_s      = 1'b0;
    miss_step_s    = 1'b0;
    case (state_r)
      IDLE: begin
        read_go_s = en_i & ~empty_i;
      end
      WAIT: begin
        read_go_s   = slot_end_s & en_i & ~empty_i;
        miss_step_s = slot_end_s & en_i & empty_i;
      end
      default: begin
        read_go_s   = 1'b0;
        miss_step_s = 1'b0;
      end
    endcase
    underrun_set_s = miss_step_s & (miss_cnt_r == MISS_ARM);
    busy_s         = (state_r != IDLE) | line_busy_s;
  end

  // Read/capture/pacing state machine; the gap counter restarts at every read and every missed slot
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_r   <= IDLE;
      rdreq_r   <= 1'b0;
      issue_r   <= 1'b0;
      data_r    <= '0;
      gap_cnt_r <= '0;
    end else begin
      rdreq_r   <= read_go_s;
      issue_r   <= 1'b0;
      gap_cnt_r <= gap_cnt_r + 8'd1;
      if (read_go_s) begin
        gap_cnt_r <= '0;
      end
      case (state_r)
        IDLE: begin
          if (read_go_s) begin
            state_r <= READ;
          end
        end
        READ: begin
          state_r <= CAPT;
        end
        CAPT: begin
          data_r  <= data_i;
          issue_r <= 1'b1;
          state_r <= WAIT;
        end
        WAIT: begin
          if (slot_end_s) begin
            if (!en_i) begin
              state_r <= DRAIN;
            end else if (read_go_s) begin
              state_r <= READ;
            end else begin
              gap_cnt_r <= '0;
            end
          end
        end
        DRAIN: begin
          if (!line_busy_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Stage-enable delay line fed by the issue pulse
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      dly_r <= '0;
    end else begin
      dly_r <= {dly_r[PIPE_LAT-2:0], issue_r};
    end
  end

  // Miss counter and sticky FIFO flags; a set wins over a coincident clear
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      miss_cnt_r <= '0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (read_go_s) begin
        miss_cnt_r <= '0;
      end else if (miss_step_s && (miss_cnt_r != 4'hF)) begin
        miss_cnt_r <= miss_cnt_r + 4'd1;
      end
      underrun_r <= underrun_set_s | (underrun_r & ~clr_i);
      overrun_r  <= full_i | (overrun_r & ~clr_i);
    end
  end

  gain_ramp #(.RATE_W(RATE_W)) u_lp_ramp (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .tgt_i  (lp_tgt_i),
    .step_i (dly_r[PIPE_LAT-1]),
    .rate_o (lp_rate_o)
  );

  gain_ramp #(.RATE_W(RATE_W)) u_hp_ramp (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .tgt_i  (hp_tgt_i),
    .step_i (dly_r[PIPE_LAT-1]),
    .rate_o (hp_rate_o)
  );

  assign rdreq_o    = rdreq_r;
  assign data_o     = data_r;
  assign issue_o    = issue_r;
  assign filt_ena_o = dly_r[CONV_LAT-1];
  assign amp_ena_o  = dly_r[PIPE_LAT-1];
  assign busy_o     = busy_s;
  assign underrun_o = underrun_r;
  assign overrun_o  = overrun_r;

endmodule

// File: tb/tb_eq_pipe_ctrl.sv
// Directed bench for eq_pipe_ctrl; cycle k is counted from the first rdreq_o (k = 0).
module tb_eq_pipe_ctrl;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        clr;
  logic        empty;
  logic        full;
  logic [23:0] fifo_q;
  logic        rdreq;
  logic [23:0] data_out;
  logic        issue;
  logic        filt_ena;
  logic        amp_ena;
  logic [7:0]  lp_tgt;
  logic [7:0]  hp_tgt;
  logic [7:0]  lp_rate;
  logic [7:0]  hp_rate;
  logic        busy;
  logic        underrun;
  logic        overrun;

  logic [23:0] mem [0:7];
  int          wr_ptr;
  int          rd_ptr;
  int          total_cnt;
  int          bad_cnt;
  int          rd_a, iss_a, amp_a, rd_c, amp_r, rd_r;

  eq_pipe_ctrl dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .en_i       (en),
    .clr_i      (clr),
    .empty_i    (empty),
    .full_i     (full),
    .data_i     (fifo_q),
    .rdreq_o    (rdreq),
    .data_o     (data_out),
    .issue_o    (issue),
    .filt_ena_o (filt_ena),
    .amp_ena_o  (amp_ena),
    .lp_tgt_i   (lp_tgt),
    .hp_tgt_i   (hp_tgt),
    .lp_rate_o  (lp_rate),
    .hp_rate_o  (hp_rate),
    .busy_o     (busy),
    .underrun_o (underrun),
    .overrun_o  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead-free FIFO read side: q valid the cycle after rdreq
  assign empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rdreq) begin
      fifo_q <= mem[rd_ptr % 8];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    mem[wr_ptr % 8] = v;
    wr_ptr++;
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    wr_ptr = 0; rd_ptr = 0; fifo_q = 24'h0;
    rd_a = 0; iss_a = 0; amp_a = 0; rd_c = 0; amp_r = 0; rd_r = 0;
    nrst = 1'b0; en = 1'b0; clr = 1'b0; full = 1'b0;
    lp_tgt = 8'd0; hp_tgt = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdreq", 32'(rdreq), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_flags", 32'({underrun, overrun, issue, amp_ena}), 32'd0);
    nrst = 1'b1;
    push(24'h000001); push(24'h000002); push(24'h000003);
    lp_tgt = 8'd3; hp_tgt = 8'd2;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= 600; k++) begin
      @(negedge clk);
      if (k <= 200 && rdreq)    rd_a++;
      if (k <= 200 && issue)    iss_a++;
      if (k <= 200 && amp_ena)  amp_a++;
      if (k >= 449 && k <= 520 && rdreq) rd_c++;
      if (k >= 533 && amp_ena)  amp_r++;
      if (k >= 533 && rdreq)    rd_r++;
      case (k)
        0:   check_eq("rdreq_t0", 32'(rdreq), 32'd1);
        2:   begin check_eq("issue_t2", 32'(issue), 32'd1); check_eq("data1", 32'(data_out), 32'h1); end
        8:   check_eq("filt_t8", 32'(filt_ena), 32'd1);
        19:  begin check_eq("amp_t19", 32'(amp_ena), 32'd1); check_eq("lp_old", 32'(lp_rate), 32'd0); end
        20:  begin check_eq("lp_1", 32'(lp_rate), 32'd1); check_eq("hp_1", 32'(hp_rate), 32'd1); end
        32:  check_eq("rdreq_t32", 32'(rdreq), 32'd1);
        34:  check_eq("data2", 32'(data_out), 32'h2);
        52:  begin check_eq("lp_2", 32'(lp_rate), 32'd2); check_eq("hp_2", 32'(hp_rate), 32'd2); end
        64:  check_eq("rdreq_t64", 32'(rdreq), 32'd1);
        66:  check_eq("data3", 32'(data_out), 32'h3);
        83:  check_eq("amp_t83", 32'(amp_ena), 32'd1);
        84:  begin check_eq("lp_3", 32'(lp_rate), 32'd3); check_eq("hp_hold", 32'(hp_rate), 32'd2); end
        191: check_eq("undr_pre", 32'(underrun), 32'd0);
        192: check_eq("undr_set", 32'(underrun), 32'd1);
        200: clr = 1'b1;
        201: begin clr = 1'b0; check_eq("undr_clr", 32'(underrun), 32'd0); end
        230: check_eq("undr_noreset", 32'(underrun), 32'd0);
        240: push(24'h000004);
        256: check_eq("rdreq_refill", 32'(rdreq), 32'd1);
        258: check_eq("data4", 32'(data_out), 32'h4);
        276: check_eq("lp_hold", 32'(lp_rate), 32'd3);
        383: begin check_eq("undr_pre2", 32'(underrun), 32'd0); clr = 1'b1; end
        384: begin clr = 1'b0; check_eq("undr_set_clr", 32'(underrun), 32'd1); end
        390: clr = 1'b1;
        391: begin clr = 1'b0; check_eq("undr_clr2", 32'(underrun), 32'd0); end
        400: begin lp_tgt = 8'd1; push(24'h000005); push(24'h000006); end
        416: check_eq("rdreq_t416", 32'(rdreq), 32'd1);
        420: full = 1'b1;
        421: begin full = 1'b0; check_eq("ovr_set", 32'(overrun), 32'd1); end
        430: check_eq("ovr_hold", 32'(overrun), 32'd1);
        436: check_eq("lp_down2", 32'(lp_rate), 32'd2);
        440: clr = 1'b1;
        441: begin clr = 1'b0; check_eq("ovr_clr", 32'(overrun), 32'd0); end
        448: check_eq("rdreq_t448", 32'(rdreq), 32'd1);
        450: check_eq("data6", 32'(data_out), 32'h6);
        451: en = 1'b0;
        455: push(24'h000007);
        467: check_eq("amp_drain", 32'(amp_ena), 32'd1);
        468: begin check_eq("lp_down1", 32'(lp_rate), 32'd1); check_eq("hp_final", 32'(hp_rate), 32'd2); end
        479: check_eq("busy_wait", 32'(busy), 32'd1);
        480: check_eq("busy_drain", 32'(busy), 32'd1);
        481: check_eq("busy_idle", 32'(busy), 32'd0);
        520: en = 1'b1;
        521: check_eq("rdreq_restart", 32'(rdreq), 32'd1);
        523: check_eq("data7", 32'(data_out), 32'h7);
        529: check_eq("filt_restart", 32'(filt_ena), 32'd1);
        532: begin
          nrst = 1'b0; en = 1'b0;
          #1;
          check_eq("rst_mid_en", 32'({rdreq, issue, filt_ena, amp_ena, busy}), 32'd0);
          check_eq("rst_mid_data", 32'(data_out), 32'd0);
          check_eq("rst_mid_rate", 32'({lp_rate, hp_rate}), 32'd0);
        end
        535: nrst = 1'b1;
        560: check_eq("busy_after_rst", 32'(busy), 32'd0);
        default: ;
      endcase
    end
    check_eq("rd_count_a", 32'(rd_a), 32'd3);
    check_eq("iss_count_a", 32'(iss_a), 32'd3);
    check_eq("amp_count_a", 32'(amp_a), 32'd3);
    check_eq("rd_after_en_low", 32'(rd_c), 32'd0);
    check_eq("amp_after_rst", 32'(amp_r), 32'd0);
    check_eq("rd_after_rst", 32'(rd_r), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
